muldiv_unit: RTL

Iterative 64-bit multiply/divide unit implementing the RV64M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operations. Sits in the EX stage beside the ALU and consumes the two register-file read operands (with forwarding already applied). It holds the pipeline via `busy` while it iterates, then presents one result with its destination register tag to the EX/MEM register for writeback.

---
 rtl/muldiv_unit_pkg.sv | 56 +++++
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV64M multiply/divide unit.
// Holds the op encodings (same values the decoder emits), the FSM state
// encoding, the latched-control payload, and small op-classification helpers.
package muldiv_unit_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned RD_W     = 5;
    localparam int unsigned OP_W     = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Control captured at acceptance and consumed in FIX.
    typedef struct packed {
        op_e             op;
        logic            neg;
        logic [RD_W-1:0] rd;
    } ctrl_t;

    function automatic logic op_is_div(op_e o);
        return o[2];
    endfunction

    function automatic logic op_is_rem(op_e o);
        return o[2] & o[1];
    endfunction

    // MULH, MULHSU, MULHU return the upper half of the product.
    function automatic logic op_is_mulh(op_e o);
        return !o[2] && (o[1:0] != 2'b00);
    endfunction

    function automatic logic a_is_signed(op_e o);
        return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic b_is_signed(op_e o);
        return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit (radix-2, 64 iterations).
// Ports:
//   clk, rst (async active-low)      clock / reset
//   start, flush                     request / synchronous abort
//   op, operand_a, operand_b, rd_in  request payload
//   ready, busy                      idle / operation in flight
//   done                             one-cycle pulse with result and rd_out valid
//   result, rd_out                   held until the next done
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [RD_W-1:0] rd_in,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out
);

    localparam int unsigned AW = 2 * XLEN;

    state_e          state;
    state_e          state_next;
    logic [CNT_W-1:0] count;
    logic [AW-1:0]   acc;     // shared working register
    logic [XLEN-1:0] opnd;    // multiplicand or divisor magnitude
    ctrl_t           ctrl;

    // Request decode at acceptance
    op_e             op_in;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            in_div;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic            neg_in;
    logic            accept;

    always_comb begin
        op_in    = op_e'(op);
        in_div   = op_is_div(op_in);
        a_neg    = a_is_signed(op_in) & operand_a[XLEN-1];
        b_neg    = b_is_signed(op_in) & operand_b[XLEN-1];
        mag_a    = a_neg ? -operand_a : operand_a;
        mag_b    = b_neg ? -operand_b : operand_b;
        div_zero = in_div && (operand_b == '0);
        div_ovf  = in_div && b_is_signed(op_in)
                   && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (&operand_b);
        special  = div_zero | div_ovf;
        // Remainder follows the dividend; product and quotient follow the sign xor.
        neg_in   = !special && (op_is_rem(op_in) ? a_neg : (a_neg ^ b_neg));
        accept   = (state == S_IDLE) && start && !flush;
    end

    // One radix-2 step of each algorithm
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_step;
    logic [XLEN:0]   div_part;
    logic [XLEN:0]   div_diff;
    logic [AW-1:0]   div_step;

    always_comb begin
        mul_sum  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step = {mul_sum, acc[XLEN-1:1]};
        // 65-bit partial remainder: the shifted-out top bit must not be lost.
        div_part = acc[AW-1:XLEN-1];
        div_diff = div_part - {1'b0, opnd};
        if (!div_diff[XLEN]) begin
            div_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            div_step = {div_part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction shared by multiply, quotient and remainder
    logic [AW-1:0]   fix_sel;
    logic [AW-1:0]   fix_val;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        if (op_is_div(ctrl.op)) begin
            fix_sel = op_is_rem(ctrl.op) ? {{XLEN{1'b0}}, acc[AW-1:XLEN]}
                                         : {{XLEN{1'b0}}, acc[XLEN-1:0]};
        end else begin
            fix_sel = acc;
        end
        fix_val = ctrl.neg ? -fix_sel : fix_sel;
        fix_res = op_is_mulh(ctrl.op) ? fix_val[AW-1:XLEN] : fix_val[XLEN-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = special ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (count == CNT_W'(XLEN - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // Registered handshake and result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            ready <= (state_next == S_IDLE);
            busy  <= (state_next != S_IDLE);
            done  <= (state == S_FIX) && !flush;
            if ((state == S_FIX) && !flush) begin
                result <= fix_res;
                rd_out <= ctrl.rd;
            end
        end
    end

    // Working register, operand and step counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            opnd  <= '0;
            ctrl  <= '0;
            count <= '0;
        end else if (accept) begin
            ctrl  <= '{op: op_in, neg: neg_in, rd: rd_in};
            count <= '0;
            opnd  <= in_div ? mag_b : mag_a;
            // Special cases preload the final quotient/remainder layout.
            if (div_zero) begin
                acc <= {operand_a, {XLEN{1'b1}}};
            end else if (div_ovf) begin
                acc <= {{XLEN{1'b0}}, operand_a};
            end else if (in_div) begin
                acc <= {{XLEN{1'b0}}, mag_a};
            end else begin
                acc <= {{XLEN{1'b0}}, mag_b};
            end
        end else if (state == S_CALC) begin
            acc   <= op_is_div(ctrl.op) ? div_step : mul_step;
            count <= count + 1'b1;
        end
    end

endmodule
